// File: rtl/mux8_arbiter_pkg.sv
// mux8_arbiter_pkg: shared constants and helpers for the 8-requester round-robin mux arbiter.
`default_nettype none

package mux8_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux8_arbiter_rr_pick8.sv
// rr_pick8: combinational round-robin search over 8 requests, starting at start_i, skipping excl_i.
`default_nettype none

module rr_pick8
  import mux8_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] start_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_REQ-1:0] cand;
  logic [SEL_W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the others.
  always_comb begin
    cand    = req_i & ~excl_i;
    found_o = 1'b0;
    idx_o   = start_i;
    pos     = start_i;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = start_i + SEL_W'(k);
      if (cand[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin owner arbiter driving the shared 8:1 mux select.
// Optional forced rotation after MAX_HOLD owned cycles: define MUX8_ARB_TIMEOUT_EN.
`default_nettype none

module mux8_arbiter
  import mux8_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             rot_pulse
);

  logic             state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             rot_q, rot_d;

  logic             own_req;
  logic             force_off;
  logic             rearb;
  logic             new_grant;
  logic [SEL_W-1:0] pick_start;
  logic [N_REQ-1:0] pick_excl;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;

  // While owning, sel_q is the owner index, so the search and exclusion derive from it.
  assign own_req    = req[sel_q];
  assign pick_start = (state_q == ST_OWN) ? sel_q + 3'd1 : ptr_q;
  assign pick_excl  = (state_q == ST_OWN) ? onehot8(sel_q) : '0;

  rr_pick8 u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

`ifdef MUX8_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  // pick_found here already means some requester other than the owner is pending.
  assign force_off = (state_q == ST_OWN) && own_req &&
                     (hold_q == HOLD_W'(MAX_HOLD)) && pick_found;

  always_comb begin
    hold_d = hold_q;
    if (new_grant || (state_d == ST_IDLE)) begin
      hold_d = '0;
    end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic [HOLD_W-1:0] unused_hold_cfg;
  assign unused_hold_cfg = HOLD_W'(MAX_HOLD);
  assign force_off       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      rot_q   <= rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rearb   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OWN;
        end
      end
      default: begin
        rearb = !own_req || force_off;
        if (rearb) begin
          ptr_d = sel_q + 3'd1;
          if (!pick_found) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  assign new_grant = ((state_q == ST_IDLE) || rearb) && pick_found;

  always_comb begin
    gnt_d  = gnt_q;
    sel_d  = sel_q;
    busy_d = busy_q;
    rot_d  = 1'b0;
    if (state_d == ST_IDLE) begin
      gnt_d  = '0;
      busy_d = 1'b0;
    end else if (new_grant) begin
      gnt_d  = onehot8(pick_idx);
      sel_d  = pick_idx;
      busy_d = 1'b1;
      rot_d  = (state_q == ST_OWN);
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign rot_pulse = rot_q;

endmodule

`default_nettype wire

// File: tb/tb_mux8_arbiter.sv
// tb_mux8_arbiter: directed vectors plus model-checked random traffic for mux8_arbiter.
`default_nettype none

module tb_mux8_arbiter;

  localparam int unsigned MAXH = 3;
`ifdef MUX8_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       rot_pulse;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux8_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .rot_pulse (rot_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                            input logic b, input logic rp);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".rot"}, 32'(rot_pulse), 32'(rp));
  endtask

  // Reference model state
  logic       m_own;
  logic [2:0] m_o, m_ptr, m_sel;
  int         m_hold;
  logic       m_rot;

  function automatic void pick(input logic [7:0] r, input logic [2:0] start,
                               output logic f, output logic [2:0] w);
    logic [2:0] j;
    f = 1'b0;
    w = 3'd0;
    for (int k = 0; k < 8; k++) begin
      j = start + 3'(k);
      if (!f && r[j]) begin
        f = 1'b1;
        w = j;
      end
    end
  endfunction

  task automatic model_reset();
    m_own = 1'b0; m_o = 3'd0; m_ptr = 3'd0; m_sel = 3'd0; m_hold = 0; m_rot = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic       f, keep;
    logic [2:0] w;
    logic [7:0] others;
    m_rot = 1'b0;
    if (!m_own) begin
      pick(r, m_ptr, f, w);
      if (f) begin
        m_own = 1'b1; m_o = w; m_sel = w; m_hold = 0;
      end
    end else begin
      others       = r;
      others[m_o]  = 1'b0;
      keep         = r[m_o];
      if (TIMEOUT && keep && (m_hold == int'(MAXH)) && (others != 8'h00)) keep = 1'b0;
      if (keep) begin
        if (m_hold < int'(MAXH)) m_hold++;
      end else begin
        m_ptr = m_o + 3'd1;
        pick(others, m_o + 3'd1, f, w);
        if (f) begin
          m_o = w; m_sel = w; m_hold = 0; m_rot = 1'b1;
        end else begin
          m_own = 1'b0;
        end
      end
    end
  endtask

  logic [7:0] exp_seq [8];
  logic [7:0] nr, prev_gnt, exp_g;
  int         waits [8];
  int         maxwait;
  logic [2:0] gidx;

  initial begin
    // Reset state
    rst_n = 1'b0;
    req   = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single request, one cycle latency
    tick(8'h04);
    expect_out("t1_grant2", 8'h04, 3'd2, 1'b1, 1'b0);

    // Owner holds, then hands off without a bubble, then wraps 7 -> 0
    tick(8'h85);
    expect_out("t2_hold", 8'h04, 3'd2, 1'b1, 1'b0);
    tick(8'h81);
    expect_out("t2_rot7", 8'h80, 3'd7, 1'b1, 1'b1);
    tick(8'h01);
    expect_out("t2_wrap0", 8'h01, 3'd0, 1'b1, 1'b1);
    tick(8'h01);
    expect_out("t2_steady", 8'h01, 3'd0, 1'b1, 1'b0);

    // Owner drops while 5 rises; 5 then releases to idle; ptr is now 6
    tick(8'h20);
    expect_out("t3_grant5", 8'h20, 3'd5, 1'b1, 1'b1);
    tick(8'h00);
    expect_out("t3_idle", 8'h00, 3'd5, 1'b0, 1'b0);
    tick(8'hFF);
    expect_out("t3_ptr6", 8'h40, 3'd6, 1'b1, 1'b0);

    // Asynchronous reset mid-grant
    tick(8'h10);
    expect_out("t4_grant4", 8'h10, 3'd4, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async.gnt", 32'(gnt), 32'h00);
    check("t4_async.busy", 32'(busy), 32'h0);
    req = 8'hFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(8'hFF);
    expect_out("t4_restart", 8'h01, 3'd0, 1'b1, 1'b0);

    // Two requesters with owner 0 holding continuously
    if (TIMEOUT) begin
      exp_seq = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01};
    end else begin
      exp_seq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    end
    for (int i = 0; i < 8; i++) begin
      tick(8'h03);
      check($sformatf("t5_hold%0d.gnt", i), 32'(gnt), 32'(exp_seq[i]));
      check($sformatf("t5_hold%0d.rot", i), 32'(rot_pulse),
            32'(TIMEOUT && (i == 3 || i == 7)));
    end
    for (int i = 0; i < 10; i++) begin
      tick(8'h01);
      check($sformatf("t5_solo%0d.gnt", i), 32'(gnt), 32'h01);
    end

    // Random traffic against the reference model
    rst_n = 1'b0;
    req   = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    prev_gnt = 8'h00;
    for (int i = 0; i < 8; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      nr = req;
      for (int i = 0; i < 8; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) nr[i] = 1'b1;
        end else if (gnt[i] && ($urandom_range(2) == 0)) begin
          nr[i] = 1'b0;
        end
      end
      model_step(nr);
      tick(nr);
      exp_g = m_own ? (8'h01 << m_o) : 8'h00;
      check("rnd.gnt", 32'(gnt), 32'(exp_g));
      check("rnd.busy", 32'(busy), 32'(m_own));
      check("rnd.sel", 32'(sel), 32'(m_sel));
      check("rnd.rot", 32'(rot_pulse), 32'(m_rot));
      check("rnd.onehot0", 32'($onehot0(gnt)), 32'h1);
      if (busy) begin
        gidx = 3'd0;
        for (int i = 0; i < 8; i++) if (gnt[i]) gidx = 3'(i);
        check("rnd.sel_vs_gnt", 32'(sel), 32'(gidx));
      end
      maxwait = 0;
      for (int i = 0; i < 8; i++) begin
        if (gnt[i] || !nr[i]) waits[i] = 0;
        else if ((gnt != prev_gnt) && (gnt != 8'h00)) waits[i]++;
        if (waits[i] > maxwait) maxwait = waits[i];
      end
      check("rnd.starve", 32'(maxwait > 7), 32'h0);
      prev_gnt = gnt;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
